mc_ctrl_fsm: RTL and testbench

//  Multi-cycle successor to the single-cycle control decoder. It sequences each instruction through

---
 rtl/mc_ctrl_fsm_if.sv | 46 ++++
 rtl/mc_ctrl_fsm.sv | 195 +++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> IR/datapath/memory signal bundle for mc_ctrl_fsm.
// master = the control FSM, slave = the IR/datapath/memory side.
interface mc_ctrl_fsm_if #(
  parameter int OP_W        = 6,
  parameter int CNT_W       = 32,
  parameter int PC_OP_LEN   = 2,
  parameter int ALU_OP_LEN  = 4,
  parameter int IEXT_OP_LEN = 2
);
  logic [OP_W-1:0]        inst_op;
  logic [OP_W-1:0]        instR_func;
  logic                   alu_zero;
  logic                   imem_ack;
  logic                   dmem_ack;
  logic                   imem_req;
  logic                   dmem_req;
  logic                   ir_write;
  logic                   pc_write;
  logic [PC_OP_LEN-1:0]   pc_op;
  logic [ALU_OP_LEN-1:0]  alu_op;
  logic                   alu_ext_mode;
  logic [IEXT_OP_LEN-1:0] iext_op;
  logic                   alu_src;
  logic [1:0]             reg_dst;
  logic [1:0]             reg_src;
  logic                   reg_write;
  logic                   mem_write;
  logic                   busy;
  logic                   fault;
  logic [CNT_W-1:0]       cyc_cnt;
  logic [CNT_W-1:0]       ret_cnt;

  modport master (
    input  inst_op, instR_func, alu_zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, ir_write, pc_write, pc_op, alu_op, alu_ext_mode,
           iext_op, alu_src, reg_dst, reg_src, reg_write, mem_write, busy, fault,
           cyc_cnt, ret_cnt
  );

  modport slave (
    output inst_op, instR_func, alu_zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, ir_write, pc_write, pc_op, alu_op, alu_ext_mode,
           iext_op, alu_src, reg_dst, reg_src, reg_write, mem_write, busy, fault,
           cyc_cnt, ret_cnt
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with req/ack memory handshakes and a sticky FAULT state.
// Optional perf counters (cyc_cnt/ret_cnt) are built only when MC_CTRL_PERF_CNT_EN is defined.
module mc_ctrl_fsm #(
  parameter int OP_W        = 6,
  parameter int TIMEOUT_CYC = 16,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mc_ctrl_fsm_if.master   bus
);
  localparam logic [1:0] PC_NEXT = 2'd0, PC_OFFSET = 2'd1, PC_IMM = 2'd2, PC_REG = 2'd3;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
                         ALU_XOR = 4'd4, ALU_NOR = 4'd5, ALU_SLT = 4'd6, ALU_SLL = 4'd7,
                         ALU_SRL = 4'd8, ALU_SRA = 4'd9;
  localparam logic [1:0] IEXT_SIGN = 2'd0, IEXT_ZERO = 2'd1, IEXT_LUI = 2'd2;
  localparam logic [1:0] DST_RD = 2'd0, DST_RT = 2'd1, DST_R31 = 2'd2, DST_NOREG = 2'd3;
  // reg_src has no NOREG code of its own; it is qualified by reg_write.
  localparam logic [1:0] SRC_ALU = 2'd0, SRC_DMEM = 2'd1, SRC_IMM = 2'd2, SRC_PC = 2'd3;

  localparam logic [OP_W-1:0] OP_R = OP_W'(6'h00), OP_J = OP_W'(6'h02), OP_JAL = OP_W'(6'h03),
    OP_BEQ = OP_W'(6'h04), OP_BNE = OP_W'(6'h05), OP_ADDIU = OP_W'(6'h09), OP_SLTI = OP_W'(6'h0a),
    OP_SLTIU = OP_W'(6'h0b), OP_ANDI = OP_W'(6'h0c), OP_ORI = OP_W'(6'h0d), OP_XORI = OP_W'(6'h0e),
    OP_LUI = OP_W'(6'h0f), OP_LW = OP_W'(6'h23), OP_SW = OP_W'(6'h2b);
  localparam logic [OP_W-1:0] F_SLL = OP_W'(6'h00), F_SRL = OP_W'(6'h02), F_SRA = OP_W'(6'h03),
    F_JR = OP_W'(6'h08), F_ADDU = OP_W'(6'h21), F_SUBU = OP_W'(6'h23), F_AND = OP_W'(6'h24),
    F_OR = OP_W'(6'h25), F_XOR = OP_W'(6'h26), F_NOR = OP_W'(6'h27), F_SLT = OP_W'(6'h2a),
    F_SLTU = OP_W'(6'h2b);

  localparam int WAIT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_e;
  typedef enum logic [3:0] {C_ALU, C_LUI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR} cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [3:0] alu_op;
    logic       ext;
    logic [1:0] iext;
    logic       alu_src;
    logic [1:0] reg_dst;
    logic [1:0] reg_src;
    logic       legal;
  } dec_t;

  function automatic dec_t decode(input logic [OP_W-1:0] op, input logic [OP_W-1:0] fn);
    dec_t d;
    d = '{cls: C_ALU, alu_op: ALU_ADD, ext: 1'b0, iext: IEXT_SIGN, alu_src: 1'b0,
          reg_dst: DST_NOREG, reg_src: SRC_ALU, legal: 1'b1};
    case (op)
      OP_R: begin
        d.reg_dst = DST_RD;
        case (fn)
          F_ADDU: d.alu_op = ALU_ADD;
          F_SUBU: d.alu_op = ALU_SUB;
          F_AND:  d.alu_op = ALU_AND;
          F_OR:   d.alu_op = ALU_OR;
          F_XOR:  d.alu_op = ALU_XOR;
          F_NOR:  d.alu_op = ALU_NOR;
          F_SLT:  begin d.alu_op = ALU_SLT; d.ext = 1'b1; end
          F_SLTU: d.alu_op = ALU_SLT;
          F_SLL:  d.alu_op = ALU_SLL;
          F_SRL:  d.alu_op = ALU_SRL;
          F_SRA:  begin d.alu_op = ALU_SRA; d.ext = 1'b1; end
          F_JR:   begin d.cls = C_JR; d.reg_dst = DST_NOREG; end
          default: d.legal = 1'b0;
        endcase
      end
      OP_ADDIU: begin d.alu_src = 1'b1; d.reg_dst = DST_RT; end
      OP_SLTI:  begin d.alu_src = 1'b1; d.reg_dst = DST_RT; d.alu_op = ALU_SLT; d.ext = 1'b1; end
      OP_SLTIU: begin d.alu_src = 1'b1; d.reg_dst = DST_RT; d.alu_op = ALU_SLT; end
      OP_ANDI:  begin d.alu_src = 1'b1; d.reg_dst = DST_RT; d.alu_op = ALU_AND; d.iext = IEXT_ZERO; end
      OP_ORI:   begin d.alu_src = 1'b1; d.reg_dst = DST_RT; d.alu_op = ALU_OR;  d.iext = IEXT_ZERO; end
      OP_XORI:  begin d.alu_src = 1'b1; d.reg_dst = DST_RT; d.alu_op = ALU_XOR; d.iext = IEXT_ZERO; end
      OP_LUI:   begin d.cls = C_LUI; d.alu_src = 1'b1; d.reg_dst = DST_RT; d.iext = IEXT_LUI;
                      d.reg_src = SRC_IMM; end
      OP_LW:    begin d.cls = C_LW; d.alu_src = 1'b1; d.reg_dst = DST_RT; d.reg_src = SRC_DMEM; end
      OP_SW:    begin d.cls = C_SW; d.alu_src = 1'b1; end
      OP_BEQ:   begin d.cls = C_BEQ; d.alu_op = ALU_SUB; end
      OP_BNE:   begin d.cls = C_BNE; d.alu_op = ALU_SUB; end
      OP_J:     d.cls = C_J;
      OP_JAL:   begin d.cls = C_JAL; d.reg_dst = DST_R31; d.reg_src = SRC_PC; end
      default:  d.legal = 1'b0;
    endcase
    return d;
  endfunction

  state_e            state_q, state_d;
  dec_t              dec_q, dec_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              req, ack;
  logic              pc_write, reg_write, taken;
  logic [1:0]        pc_op;

  always_comb begin
    state_d = state_q;
    dec_d   = dec_q;
    wait_d  = wait_q;
    req     = (state_q == S_FETCH) || (state_q == S_MEM);
    ack     = (state_q == S_FETCH) ? bus.imem_ack : bus.dmem_ack;
    case (state_q)
      S_FETCH:  if (bus.imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        dec_d   = decode(bus.inst_op, bus.instR_func);
        state_d = dec_d.legal ? S_EXEC : S_FAULT;
      end
      S_EXEC: begin
        case (dec_q.cls)
          C_LW, C_SW:   state_d = S_MEM;
          C_ALU, C_LUI: state_d = S_WB;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM:   if (bus.dmem_ack) state_d = (dec_q.cls == C_SW) ? S_FETCH : S_WB;
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FAULT;
    endcase
    // Bounded wait: the TIMEOUT_CYC-th consecutive unacked request cycle trips FAULT.
    if (TIMEOUT_CYC != 0 && req && !ack) begin
      if (wait_q == WAIT_W'(TIMEOUT_CYC - 1)) state_d = S_FAULT;
      else                                     wait_d  = wait_q + 1'b1;
    end
    if (state_d != state_q) wait_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      dec_q   <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    taken     = (dec_q.cls == C_BEQ) ? bus.alu_zero : !bus.alu_zero;
    pc_write  = 1'b0;
    reg_write = 1'b0;
    pc_op     = PC_NEXT;
    case (state_q)
      S_EXEC: begin
        case (dec_q.cls)
          C_BEQ, C_BNE: begin pc_write = 1'b1; pc_op = taken ? PC_OFFSET : PC_NEXT; end
          C_J:          begin pc_write = 1'b1; pc_op = PC_IMM; end
          C_JAL:        begin pc_write = 1'b1; pc_op = PC_IMM; reg_write = 1'b1; end
          C_JR:         begin pc_write = 1'b1; pc_op = PC_REG; end
          default: ;
        endcase
      end
      S_MEM:   pc_write = bus.dmem_ack && (dec_q.cls == C_SW);
      S_WB:    begin pc_write = 1'b1; reg_write = 1'b1; end
      default: ;
    endcase
  end

  // Every output is forced low while reset is asserted, including ack-driven strobes.
  assign bus.imem_req     = rst_n && (state_q == S_FETCH);
  assign bus.ir_write     = rst_n && (state_q == S_FETCH) && bus.imem_ack;
  assign bus.dmem_req     = rst_n && (state_q == S_MEM);
  assign bus.mem_write    = rst_n && (state_q == S_MEM) && (dec_q.cls == C_SW);
  assign bus.pc_write     = rst_n && pc_write;
  assign bus.reg_write    = rst_n && reg_write;
  assign bus.pc_op        = rst_n ? pc_op : PC_NEXT;
  assign bus.alu_op       = rst_n ? dec_q.alu_op : 4'd0;
  assign bus.alu_ext_mode = rst_n && dec_q.ext;
  assign bus.iext_op      = rst_n ? dec_q.iext : 2'd0;
  assign bus.alu_src      = rst_n && dec_q.alu_src;
  assign bus.reg_dst      = rst_n ? dec_q.reg_dst : 2'd0;
  assign bus.reg_src      = rst_n ? dec_q.reg_src : 2'd0;
  assign bus.fault        = rst_n && (state_q == S_FAULT);
  assign bus.busy         = rst_n && (state_q != S_FAULT) && !((state_q == S_FETCH) && !bus.imem_ack);

`ifdef MC_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (state_q != S_FAULT) begin
      cyc_q <= cyc_q + 1'b1;
      if (pc_write) ret_q <= ret_q + 1'b1;
    end
  end

  assign bus.cyc_cnt = cyc_q;
  assign bus.ret_cnt = ret_q;
`else
  assign bus.cyc_cnt = '0;
  assign bus.ret_cnt = '0;
`endif
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: per-instruction vector table plus hand sequences for
// memory waits, timeout fault, and the perf counters (MC_CTRL_PERF_CNT_EN aware).
module tb_mc_ctrl_fsm;
  localparam int OP_W = 6, CNT_W = 32, TMO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mc_ctrl_fsm_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus ();
  mc_ctrl_fsm #(.OP_W(OP_W), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    string      name;
    logic [5:0] op, fn;
    logic       zero;
    int         lat;      // cycle of pc_write counted from the fetch cycle; 0 = expect FAULT
    logic [1:0] pc_op;
    logic       rw;
    logic [1:0] dst, src;
    logic [3:0] alu;
    logic       asrc;
    logic [1:0] iext;
    logic       ext;
    logic       mw;
  } vec_t;

  vec_t vt[18];
  int n_cmp = 0, n_fail = 0;

  int         cap_lat, cap_end;
  logic       cap_irw, cap_mw, cap_fault, cap_rw, cap_asrc, cap_ext;
  logic [1:0] cap_pc, cap_dst, cap_src, cap_iext;
  logic [3:0] cap_alu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  // Runs one instruction with acks always high (stray acks included) until the next fetch.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zero);
    cap_lat = 0; cap_end = 0; cap_irw = 0; cap_mw = 0; cap_fault = 0; cap_rw = 0;
    cap_pc = 0; cap_dst = 0; cap_src = 0; cap_alu = 0; cap_asrc = 0; cap_iext = 0; cap_ext = 0;
    bus.inst_op = op; bus.instR_func = fn; bus.alu_zero = zero;
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (c > 1 && bus.imem_req) begin cap_end = c; break; end
      if (c == 1) cap_irw = bus.ir_write;
      if (bus.mem_write) cap_mw = 1'b1;
      if (bus.pc_write && cap_lat == 0) begin
        cap_lat = c; cap_pc = bus.pc_op; cap_rw = bus.reg_write; cap_dst = bus.reg_dst;
        cap_src = bus.reg_src; cap_alu = bus.alu_op; cap_asrc = bus.alu_src;
        cap_iext = bus.iext_op; cap_ext = bus.alu_ext_mode;
      end
      if (bus.fault) begin cap_fault = 1'b1; break; end
      tick();
    end
  endtask

  initial begin
    //          name     op     fn     z  lat pc rw dst src alu as ie ex mw
    vt[0]  = '{"addu",  6'h00, 6'h21, 0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{"subu",  6'h00, 6'h23, 0, 4, 0, 1, 0, 0, 1, 0, 0, 0, 0};
    vt[2]  = '{"slt",   6'h00, 6'h2a, 0, 4, 0, 1, 0, 0, 6, 0, 0, 1, 0};
    vt[3]  = '{"sll",   6'h00, 6'h00, 0, 4, 0, 1, 0, 0, 7, 0, 0, 0, 0};
    vt[4]  = '{"addiu", 6'h09, 6'h00, 0, 4, 0, 1, 1, 0, 0, 1, 0, 0, 0};
    vt[5]  = '{"ori",   6'h0d, 6'h00, 0, 4, 0, 1, 1, 0, 3, 1, 1, 0, 0};
    vt[6]  = '{"lui",   6'h0f, 6'h00, 0, 4, 0, 1, 1, 2, 0, 1, 2, 0, 0};
    vt[7]  = '{"lw",    6'h23, 6'h00, 0, 5, 0, 1, 1, 1, 0, 1, 0, 0, 0};
    vt[8]  = '{"sw",    6'h2b, 6'h00, 0, 4, 0, 0, 3, 0, 0, 1, 0, 0, 1};
    vt[9]  = '{"beq_t", 6'h04, 6'h00, 1, 3, 1, 0, 3, 0, 1, 0, 0, 0, 0};
    vt[10] = '{"beq_n", 6'h04, 6'h00, 0, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0};
    vt[11] = '{"bne_t", 6'h05, 6'h00, 0, 3, 1, 0, 3, 0, 1, 0, 0, 0, 0};
    vt[12] = '{"bne_n", 6'h05, 6'h00, 1, 3, 0, 0, 3, 0, 1, 0, 0, 0, 0};
    vt[13] = '{"j",     6'h02, 6'h00, 0, 3, 2, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[14] = '{"jal",   6'h03, 6'h00, 0, 3, 2, 1, 2, 3, 0, 0, 0, 0, 0};
    vt[15] = '{"jr",    6'h00, 6'h08, 0, 3, 3, 0, 3, 0, 0, 0, 0, 0, 0};
    vt[16] = '{"badop", 6'h3f, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[17] = '{"badfn", 6'h00, 6'h3f, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    bus.inst_op = '0; bus.instR_func = '0; bus.alu_zero = 1'b0;
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    // Reset: everything low even with acks asserted.
    check("rst_ctl", {31'd0, |{bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write,
                      bus.reg_write, bus.mem_write, bus.busy, bus.fault}}, 32'd0);
    check("rst_sel", {16'd0, bus.pc_op, bus.alu_op, bus.alu_ext_mode, bus.iext_op, bus.alu_src,
                      bus.reg_dst, bus.reg_src, 1'b0}, 32'd0);
    check("rst_cyc", bus.cyc_cnt, 32'd0);
    rst_n = 1'b1; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    #1;
    check("post_rst_imem_req", {31'd0, bus.imem_req}, 32'd1);
    check("post_rst_busy", {31'd0, bus.busy}, 32'd0);

    for (int i = 0; i < 18; i++) begin
      run_instr(vt[i].op, vt[i].fn, vt[i].zero);
      if (vt[i].lat == 0) begin
        check({vt[i].name, "_fault"}, {31'd0, cap_fault}, 32'd1);
        check({vt[i].name, "_nopcw"}, cap_lat, 32'd0);
        do_reset();
      end else begin
        check({vt[i].name, "_irw"},  {31'd0, cap_irw}, 32'd1);
        check({vt[i].name, "_lat"},  cap_lat, vt[i].lat);
        check({vt[i].name, "_next"}, cap_end, vt[i].lat + 1);
        check({vt[i].name, "_pcop"}, {30'd0, cap_pc}, {30'd0, vt[i].pc_op});
        check({vt[i].name, "_rw"},   {31'd0, cap_rw}, {31'd0, vt[i].rw});
        check({vt[i].name, "_dst"},  {30'd0, cap_dst}, {30'd0, vt[i].dst});
        check({vt[i].name, "_src"},  {30'd0, cap_src}, {30'd0, vt[i].src});
        check({vt[i].name, "_alu"},  {28'd0, cap_alu}, {28'd0, vt[i].alu});
        check({vt[i].name, "_asrc"}, {31'd0, cap_asrc}, {31'd0, vt[i].asrc});
        check({vt[i].name, "_iext"}, {30'd0, cap_iext}, {30'd0, vt[i].iext});
        check({vt[i].name, "_ext"},  {31'd0, cap_ext}, {31'd0, vt[i].ext});
        check({vt[i].name, "_mw"},   {31'd0, cap_mw}, {31'd0, vt[i].mw});
      end
    end

    // lw with three dmem wait cycles: ack on c7, write-back on c8, next fetch c9.
    bus.inst_op = 6'h23; bus.instR_func = 6'h00; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    #1;
    check("lw3_irw", {31'd0, bus.ir_write}, 32'd1);
    tick(); bus.imem_ack = 1'b0;
    #1;
    check("lw3_busy_dec", {31'd0, bus.busy}, 32'd1);
    check("lw3_dec_irw", {31'd0, bus.ir_write}, 32'd0);
    tick(); tick(); tick(); tick();
    #1;
    check("lw3_c6_dreq", {31'd0, bus.dmem_req}, 32'd1);
    check("lw3_c6_rw", {31'd0, bus.reg_write}, 32'd0);
    tick(); bus.dmem_ack = 1'b1;
    #1;
    check("lw3_c7_rw", {31'd0, bus.reg_write}, 32'd0);
    tick(); bus.dmem_ack = 1'b0;
    #1;
    check("lw3_c8_rw", {31'd0, bus.reg_write}, 32'd1);
    check("lw3_c8_src", {30'd0, bus.reg_src}, 32'd1);
    check("lw3_c8_pcw", {31'd0, bus.pc_write}, 32'd1);
    tick();
    #1;
    check("lw3_c9_ireq", {31'd0, bus.imem_req}, 32'd1);
    check("lw3_c9_rw", {31'd0, bus.reg_write}, 32'd0);

    // sw waiting 15 cycles (one short of the timeout) must still complete.
    bus.inst_op = 6'h2b; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    tick(); bus.imem_ack = 1'b0;
    tick(); tick();
    for (int c = 0; c < 15; c++) tick();
    bus.dmem_ack = 1'b1;
    #1;
    check("sw15_pcw", {31'd0, bus.pc_write}, 32'd1);
    check("sw15_mw", {31'd0, bus.mem_write}, 32'd1);
    check("sw15_fault", {31'd0, bus.fault}, 32'd0);
    tick(); bus.dmem_ack = 1'b0;
    #1;
    check("sw15_ireq", {31'd0, bus.imem_req}, 32'd1);

    // imem timeout: fault appears on the 17th cycle, sticky, cleared by a 1-cycle reset.
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      #1;
      if (c == 1)  check("tmo_busy_wait", {31'd0, bus.busy}, 32'd0);
      if (c == 16) check("tmo_c16_fault", {31'd0, bus.fault}, 32'd0);
      tick();
    end
    #1;
    check("tmo_c17_fault", {31'd0, bus.fault}, 32'd1);
    check("tmo_c17_ireq", {31'd0, bus.imem_req}, 32'd0);
    check("tmo_c17_busy", {31'd0, bus.busy}, 32'd0);
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    tick(); tick(); tick();
    #1;
    check("tmo_sticky", {31'd0, bus.fault}, 32'd1);
    check("tmo_sticky_irw", {31'd0, bus.ir_write}, 32'd0);
    rst_n = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("tmo_clr_fault", {31'd0, bus.fault}, 32'd0);
    check("tmo_clr_ireq", {31'd0, bus.imem_req}, 32'd1);

    // Perf: 10 back-to-back addu, then a reset landing in WB.
    do_reset();
    for (int k = 0; k < 10; k++) run_instr(6'h00, 6'h21, 1'b0);
`ifdef MC_CTRL_PERF_CNT_EN
    check("perf_cyc40", bus.cyc_cnt, 32'd40);
    check("perf_ret10", bus.ret_cnt, 32'd10);
`else
    check("perf_cyc_tied", bus.cyc_cnt, 32'd0);
    check("perf_ret_tied", bus.ret_cnt, 32'd0);
`endif
    tick(); bus.imem_ack = 1'b0;
    tick(); tick();
    #1;
    check("wb_pcw_pre", {31'd0, bus.pc_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("wb_rst_rw", {31'd0, bus.reg_write}, 32'd0);
    check("wb_rst_pcw", {31'd0, bus.pc_write}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("wb_rst_cyc", bus.cyc_cnt, 32'd0);
    check("wb_rst_ret", bus.ret_cnt, 32'd0);
    check("wb_rst_ireq", {31'd0, bus.imem_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
